// File: rtl/switch_pio_pkg.sv
// Shared constants for the switch/button input port: register addresses,
// edge-type encodings and the per-bit edge selector.
package switch_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam logic [1:0] ARM_DONE = 2'd3;

  function automatic logic [31:0] edge_sel(input int edge_type,
                                           input logic [31:0] cur,
                                           input logic [31:0] prev);
    logic [31:0] rise;
    logic [31:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (edge_type)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Single-line debounce filter: the output follows din only after din has
// disagreed with it for DEBOUNCE_CYCLES consecutive clocks.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (load) begin
      lvl_d = din;
      cnt_d = '0;
    end else if (din == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      lvl_d = ~lvl_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  // While arming, pass the synchronized level straight through so the edge
  // detector sees a settled history by the time it is enabled.
  assign dout = load ? din : lvl_q;

endmodule

// File: rtl/switch_pio_in.sv
// Avalon-MM input port for slide switches / push buttons with edge capture,
// interrupt mask and level IRQ. SWITCH_PIO_DEBOUNCE_EN adds per-bit debounce.
module switch_pio_in
  import switch_pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] lvl_prev_q, lvl_prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [1:0]       arm_q, arm_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] edge_det;
  logic             armed;
  logic             wr;
  logic             unused_wd;

  assign armed     = (arm_q == ARM_DONE);
  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

`ifdef SWITCH_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .reset(reset),
      .load (~armed),
      .din  (sync2_q[i]),
      .dout (lvl[i])
    );
  end
`else
  localparam int deb_unused = DEBOUNCE_CYCLES;
  assign lvl = sync2_q;
`endif

  always_comb begin
    sync1_d    = in_port;
    sync2_d    = sync1_q;
    lvl_prev_d = lvl;
    arm_d      = armed ? arm_q : arm_q + 2'd1;
    edge_det   = armed ? WIDTH'(edge_sel(EDGE_TYPE, 32'(lvl), 32'(lvl_prev_q))) : '0;

    mask_d = mask_q;
    if (wr && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];

    // Clear first, then OR in new edges so a coincident edge is never lost.
    cap_d = cap_q;
    if (wr && address == ADDR_EDGE) cap_d = cap_q & ~writedata[WIDTH-1:0];
    cap_d = cap_d | edge_det;

    case (address)
      ADDR_DATA: readdata_d = 32'(lvl);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(cap_q);
      default:   readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      arm_q      <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_prev_q <= lvl_prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      arm_q      <= arm_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_switch_pio_in.sv
// Self-checking bench for switch_pio_in: directed register scenarios plus a
// randomized run checked every cycle against a behavioural model.
module tb_switch_pio_in;

  localparam int W   = 10;
  localparam int ET  = 0;
  localparam int DEB = 8;
`ifdef SWITCH_PIO_DEBOUNCE_EN
  localparam int DBL = DEB;
`else
  localparam int DBL = 0;
`endif
  // in_port change before edge k shows up in EDGE_CAP at edge k+LAT
  localparam int LAT    = 2 + DBL;
  localparam int SETTLE = LAT + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  in_port = '1;
  logic [31:0]   readdata;
  logic          irq;

  always #5 clk = ~clk;

  switch_pio_in #(.WIDTH(W), .EDGE_TYPE(ET), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_hist[$];        // in_port samples since reset, newest first
  int           m_arm;            // edges since reset, saturating at 3
  logic [W-1:0] m_lvl, m_lvl_prev, m_cap, m_mask, m_lvl_reg;
  logic [31:0]  m_rd;
  int           m_run[W];

  task automatic model_step();
    logic [W-1:0] s2_pre, s2_post, edges, clr;
    logic [31:0]  rd_n;
    bit           wr;
    if (reset) begin
      m_hist.delete();
      m_arm = 0;
      m_lvl = '0; m_lvl_prev = '0; m_cap = '0; m_mask = '0; m_lvl_reg = '0;
      m_rd = 32'd0;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      wr = chipselect && !write_n;
      case (address)
        2'd0:    rd_n = 32'(m_lvl);
        2'd2:    rd_n = 32'(m_mask);
        2'd3:    rd_n = 32'(m_cap);
        default: rd_n = 32'd0;
      endcase
      edges = '0;
      if (m_arm >= 3)
        for (int i = 0; i < W; i++)
          if (m_lvl[i] != m_lvl_prev[i] && (ET == 2 || m_lvl[i] == (ET == 0)))
            edges[i] = 1'b1;
      clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~clr) | edges;
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      s2_pre = (m_hist.size() >= 2) ? m_hist[1] : '0;
`ifdef SWITCH_PIO_DEBOUNCE_EN
      for (int i = 0; i < W; i++) begin
        if (m_arm < 3) begin
          m_lvl_reg[i] = s2_pre[i];
          m_run[i] = 0;
        end else if (s2_pre[i] != m_lvl_reg[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl_reg[i] = ~m_lvl_reg[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
`endif
      m_lvl_prev = m_lvl;
      m_hist.push_front(in_port);
      if (m_hist.size() > 2) void'(m_hist.pop_back());
      if (m_arm < 3) m_arm++;
      s2_post = (m_hist.size() >= 2) ? m_hist[1] : '0;
`ifdef SWITCH_PIO_DEBOUNCE_EN
      m_lvl = (m_arm >= 3) ? m_lvl_reg : s2_post;
`else
      m_lvl = s2_post;
`endif
      m_rd = rd_n;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_readdata", readdata, m_rd);
      check("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    address = a;
    tick();
    v = readdata;
  endtask

  initial begin
    logic [31:0] v;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    ticks(2);
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);

    // lines high through reset must not produce edges
    reset = 1'b0;
    ticks(5);
    rd_reg(2'd3, v); check("cap_after_reset_high", v, 32'd0);
    check("irq_after_reset_high", {31'd0, irq}, 32'd0);
    rd_reg(2'd0, v); check("data_after_reset", v, 32'h3FF);

    // single rising edge on bit 0
    in_port = '0;
    ticks(SETTLE);
    wr_reg(2'd3, 32'h3FF);
    wr_reg(2'd2, 32'h001);
    in_port[0] = 1'b1;
    ticks(LAT);
    check("irq_before_capture", {31'd0, irq}, 32'd0);
    tick();
    check("irq_on_capture", {31'd0, irq}, 32'd1);
    rd_reg(2'd3, v); check("cap_bit0", v, 32'h001);
    wr_reg(2'd3, 32'h001);
    check("irq_after_clear", {31'd0, irq}, 32'd0);
    rd_reg(2'd3, v); check("cap_cleared", v, 32'd0);

    // edge on bit 4 coincides with its clear: set wins
    in_port[4] = 1'b1;
    ticks(LAT);
    wr_reg(2'd3, 32'h010);
    rd_reg(2'd3, v); check("edge_beats_clear", v, 32'h010);
    wr_reg(2'd3, 32'h3EF);
    rd_reg(2'd3, v); check("zero_bits_keep", v, 32'h010);
    wr_reg(2'd3, 32'h010);
    rd_reg(2'd3, v); check("bit4_cleared", v, 32'd0);

    // masked capture, then unmask
    wr_reg(2'd2, 32'd0);
    in_port = '0;
    ticks(SETTLE);
    wr_reg(2'd3, 32'h3FF);
    in_port = 10'h201;
    ticks(SETTLE);
    rd_reg(2'd3, v); check("cap_masked", v, 32'h201);
    check("irq_masked", {31'd0, irq}, 32'd0);
    wr_reg(2'd2, 32'hFFFF_F200);
    check("irq_on_mask_write", {31'd0, irq}, 32'd1);
    rd_reg(2'd2, v); check("mask_readback", v, 32'h200);

    // reset in the middle of pending events
    wr_reg(2'd3, 32'h3FF);
    wr_reg(2'd2, 32'h0F0);
    in_port = 10'h0F0;
    ticks(SETTLE);
    rd_reg(2'd3, v); check("cap_before_reset", v, 32'h0F0);
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    tick();
    check("readdata_mid_reset", readdata, 32'd0);
    check("irq_mid_reset", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    rd_reg(2'd2, v); check("mask_after_reset", v, 32'd0);
    rd_reg(2'd3, v); check("cap_after_reset", v, 32'd0);

`ifdef SWITCH_PIO_DEBOUNCE_EN
    in_port = '0;
    ticks(SETTLE);
    wr_reg(2'd3, 32'h3FF);
    in_port[2] = 1'b1;
    ticks(5);
    in_port[2] = 1'b0;
    ticks(SETTLE);
    rd_reg(2'd0, v); check("glitch_data", v, 32'd0);
    rd_reg(2'd3, v); check("glitch_cap", v, 32'd0);
    in_port[2] = 1'b1;
    ticks(SETTLE);
    rd_reg(2'd0, v); check("debounced_data", v, 32'h004);
    rd_reg(2'd3, v); check("debounced_cap", v, 32'h004);
`endif

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3 + 2 * DBL) == 0)
        in_port = in_port ^ W'($urandom & $urandom);
      chipselect = ($urandom_range(0, 1) == 1);
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      tick();
    end
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    tick();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
